// File: rtl/pwm_sequencer_if.sv
// Host/pwm-facing bus of pwm_sequencer.
//   master: host side (drives table writes, sequence control; observes status and pwm drive)
//   slave : pwm_sequencer side
// Ports: cfg_we/cfg_addr/cfg_width/cfg_hold table write, seq_len/loop/start/stop control,
//        busy/done/cur_index status, pwm_update/pwm_pulse_width/pwm_enable to the pwm.
interface pwm_sequencer_if #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned WAVE_LEN   = 1024,
    parameter int unsigned HOLD_WIDTH = 16
);
    localparam int unsigned WAVE_LEN_WIDTH = $clog2(WAVE_LEN + 1);
    localparam int unsigned ADDR_WIDTH     = $clog2(DEPTH);
    localparam int unsigned LEN_WIDTH      = $clog2(DEPTH + 1);

    logic                      cfg_we;
    logic [ADDR_WIDTH-1:0]     cfg_addr;
    logic [WAVE_LEN_WIDTH-1:0] cfg_width;
    logic [HOLD_WIDTH-1:0]     cfg_hold;
    logic [LEN_WIDTH-1:0]      seq_len;
    logic                      loop;
    logic                      start;
    logic                      stop;
    logic                      busy;
    logic                      done;
    logic [ADDR_WIDTH-1:0]     cur_index;
    logic                      pwm_update;
    logic [WAVE_LEN_WIDTH-1:0] pwm_pulse_width;
    logic                      pwm_enable;

    modport master (
        output cfg_we, cfg_addr, cfg_width, cfg_hold, seq_len, loop, start, stop,
        input  busy, done, cur_index, pwm_update, pwm_pulse_width, pwm_enable
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_width, cfg_hold, seq_len, loop, start, stop,
        output busy, done, cur_index, pwm_update, pwm_pulse_width, pwm_enable
    );
endinterface

// File: rtl/pwm_sequencer.sv
// Plays a table of (pulse_width, hold_periods) steps into a pwm instance, advancing only
// on PWM period boundaries. One-shot or looping playback.
// Ports: clk, reset_n (async active-low), bus (pwm_sequencer_if.slave: table write,
//        seq_len/loop/start/stop control, busy/done/cur_index status, pwm drive).
// Assumes DEPTH >= 2 and WAVE_LEN*WAVE_WEIGHT >= 2.
module pwm_sequencer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAVE_LEN    = 1024,
    parameter int unsigned WAVE_WEIGHT = 1024,
    parameter int unsigned HOLD_WIDTH  = 16
) (
    input logic             clk,
    input logic             reset_n,
    pwm_sequencer_if.slave  bus
);
    localparam int unsigned WAVE_LEN_WIDTH = $clog2(WAVE_LEN + 1);
    localparam int unsigned ADDR_WIDTH     = $clog2(DEPTH);
    localparam int unsigned LEN_WIDTH      = $clog2(DEPTH + 1);
    localparam int unsigned PERIOD         = WAVE_LEN * WAVE_WEIGHT;
    localparam int unsigned CNT_WIDTH      = $clog2(PERIOD);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

    logic [WAVE_LEN_WIDTH-1:0] width_mem [DEPTH];
    logic [HOLD_WIDTH-1:0]     hold_mem  [DEPTH];

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     idx_q, idx_d;
    logic [HOLD_WIDTH-1:0]     hold_q, hold_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic                      loop_q, loop_d;
    logic [WAVE_LEN_WIDTH-1:0] width_q, width_d;
    logic                      upd_q, upd_d;
    logic                      busy_q, done_q, en_q;

    logic                      period_tick_c;
    logic                      last_c;
    logic                      start_ok_c;
    logic                      fetch_c;
    logic [ADDR_WIDTH-1:0]     fetch_idx_c;

    // Step table; writes accepted in every state, read only when a step is fetched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                width_mem[i] <= '0;
                hold_mem[i]  <= '0;
            end
        end else if (bus.cfg_we) begin
            width_mem[bus.cfg_addr] <= bus.cfg_width;
            hold_mem[bus.cfg_addr]  <= bus.cfg_hold;
        end
    end

    // Next-state, counters and next output values.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        loop_d      = loop_q;
        width_d     = width_q;
        upd_d       = 1'b0;
        fetch_c     = 1'b0;
        fetch_idx_c = '0;

        period_tick_c = (cnt_q == CNT_WIDTH'(PERIOD - 1));
        last_c        = (LEN_WIDTH'(idx_q) + LEN_WIDTH'(1)) >= len_q;
        start_ok_c    = bus.start && (bus.seq_len != '0);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok_c) begin
                    state_d = ST_LOAD;
                    len_d   = (bus.seq_len > LEN_WIDTH'(DEPTH)) ? LEN_WIDTH'(DEPTH) : bus.seq_len;
                    loop_d  = bus.loop;
                    fetch_c = 1'b1;
                    // LOAD counts as the first clock of the first period.
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                cnt_d   = cnt_q + CNT_WIDTH'(1);
            end
            ST_RUN: begin
                cnt_d = period_tick_c ? '0 : cnt_q + CNT_WIDTH'(1);
                if (period_tick_c) begin
                    if (hold_q > HOLD_WIDTH'(1)) begin
                        hold_d = hold_q - HOLD_WIDTH'(1);
                    end else if (!last_c) begin
                        fetch_c     = 1'b1;
                        fetch_idx_c = idx_q + ADDR_WIDTH'(1);
                    end else if (loop_q) begin
                        fetch_c     = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // stop wins over start and over a period boundary.
        if (bus.stop) begin
            state_d = ST_IDLE;
            fetch_c = 1'b0;
            idx_d   = '0;
        end

        if (fetch_c) begin
            idx_d   = fetch_idx_c;
            width_d = (width_mem[fetch_idx_c] > WAVE_LEN_WIDTH'(WAVE_LEN)) ?
                      WAVE_LEN_WIDTH'(WAVE_LEN) : width_mem[fetch_idx_c];
            hold_d  = (hold_mem[fetch_idx_c] == '0) ? HOLD_WIDTH'(1) : hold_mem[fetch_idx_c];
            upd_d   = 1'b1;
        end
    end

    // State, counters and registered outputs (outputs follow the next state).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            width_q <= '0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            width_q <= width_d;
            upd_q   <= upd_d;
            busy_q  <= (state_d == ST_LOAD) || (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
            en_q    <= (state_d == ST_RUN);
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.cur_index       = idx_q;
    assign bus.pwm_update      = upd_q;
    assign bus.pwm_pulse_width = width_q;
    assign bus.pwm_enable      = en_q;
endmodule

// File: tb/tb_pwm_sequencer.sv
module tb_pwm_sequencer;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned WAVE_LEN    = 4;
    localparam int unsigned WAVE_WEIGHT = 2;
    localparam int unsigned HOLD_WIDTH  = 8;
    localparam int unsigned PER         = WAVE_LEN * WAVE_WEIGHT;
    localparam int unsigned WLW         = $clog2(WAVE_LEN + 1);
    localparam int unsigned AW          = $clog2(DEPTH);
    localparam int unsigned LW          = $clog2(DEPTH + 1);

    typedef struct {
        int w;
        int h;
        int len;
        int exp_w;
        int exp_per;
    } vec_t;

    typedef struct {
        bit upd;
        int w;
        int idx;
        bit busy;
        bit done;
        bit en;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_w [DEPTH];
    int   m_h [DEPTH];
    vec_t vecs [6];

    always #5 clk = ~clk;

    pwm_sequencer_if #(.DEPTH(DEPTH), .WAVE_LEN(WAVE_LEN), .HOLD_WIDTH(HOLD_WIDTH)) bus ();

    pwm_sequencer #(
        .DEPTH(DEPTH), .WAVE_LEN(WAVE_LEN), .WAVE_WEIGHT(WAVE_WEIGHT), .HOLD_WIDTH(HOLD_WIDTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic wr(input int a, input int w, input int h);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = AW'(a);
        bus.cfg_width = WLW'(w);
        bus.cfg_hold  = HOLD_WIDTH'(h);
        m_w[a] = w;
        m_h[a] = h;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic go_idle();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    // Expected outputs c cycles after the LOAD cycle, from the step schedule:
    // step k starts at the sum of earlier step lengths, each PER*max(hold,1) clocks long.
    task automatic model(input int c, input int len_in, input bit lp, input int stop_at,
                         output exp_t e);
        int len, t, idx, dur;
        e = '{upd: 1'b0, w: 0, idx: 0, busy: 1'b0, done: 1'b0, en: 1'b0};
        len = (len_in > int'(DEPTH)) ? int'(DEPTH) : len_in;
        if (len == 0 || c >= stop_at) return;
        t = 0;
        for (int k = 0; k < 1000; k++) begin
            idx = k % len;
            dur = int'(PER) * ((m_h[idx] == 0) ? 1 : m_h[idx]);
            if (c < t + dur) begin
                e.upd  = (c == t);
                e.w    = (m_w[idx] > int'(WAVE_LEN)) ? int'(WAVE_LEN) : m_w[idx];
                e.idx  = idx;
                e.busy = 1'b1;
                e.en   = (c > 0);
                return;
            end
            t = t + dur;
            if (!lp && k + 1 == len) begin
                e.done = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_check(input string nm, input int len, input bit lp, input int ncyc,
                             input int stop_at);
        exp_t e;
        bus.seq_len = LW'(len);
        bus.loop    = lp;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            model(c, len, lp, stop_at, e);
            chk($sformatf("%s.busy@%0d", nm, c), int'(bus.busy), int'(e.busy));
            chk($sformatf("%s.done@%0d", nm, c), int'(bus.done), int'(e.done));
            chk($sformatf("%s.en@%0d", nm, c), int'(bus.pwm_enable), int'(e.en));
            chk($sformatf("%s.upd@%0d", nm, c), int'(bus.pwm_update), int'(e.upd));
            if (e.upd) chk($sformatf("%s.width@%0d", nm, c), int'(bus.pwm_pulse_width), e.w);
            if (e.busy) chk($sformatf("%s.idx@%0d", nm, c), int'(bus.cur_index), e.idx);
            bus.stop = (c + 1 == stop_at);
            tick();
        end
        go_idle();
    endtask

    initial begin
        vecs[0] = '{w: 0, h: 0, len: 1, exp_w: 0, exp_per: 1};
        vecs[1] = '{w: 4, h: 1, len: 1, exp_w: 4, exp_per: 1};
        vecs[2] = '{w: 5, h: 0, len: 1, exp_w: 4, exp_per: 1};
        vecs[3] = '{w: 7, h: 3, len: 1, exp_w: 4, exp_per: 3};
        vecs[4] = '{w: 2, h: 2, len: 1, exp_w: 2, exp_per: 2};
        vecs[5] = '{w: 3, h: 1, len: 0, exp_w: 0, exp_per: 0};
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_w[i] = 0;
            m_h[i] = 0;
        end

        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_width = '0; bus.cfg_hold = '0;
        bus.seq_len = '0; bus.loop = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;

        // Reset state.
        repeat (3) tick();
        chk("rst.busy", int'(bus.busy), 0);
        chk("rst.done", int'(bus.done), 0);
        chk("rst.en", int'(bus.pwm_enable), 0);
        chk("rst.upd", int'(bus.pwm_update), 0);
        chk("rst.width", int'(bus.pwm_pulse_width), 0);
        chk("rst.idx", int'(bus.cur_index), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Single-step vectors: width clamp, hold 0 -> 1, seq_len 0 ignored.
        foreach (vecs[i]) begin
            wr(0, vecs[i].w, vecs[i].h);
            bus.seq_len = LW'(vecs[i].len);
            bus.loop    = 1'b0;
            bus.start   = 1'b1;
            tick();
            bus.start = 1'b0;
            if (vecs[i].exp_per == 0) begin
                chk($sformatf("vec%0d.busy", i), int'(bus.busy), 0);
                chk($sformatf("vec%0d.upd", i), int'(bus.pwm_update), 0);
            end else begin
                chk($sformatf("vec%0d.upd", i), int'(bus.pwm_update), 1);
                chk($sformatf("vec%0d.width", i), int'(bus.pwm_pulse_width), vecs[i].exp_w);
                chk($sformatf("vec%0d.busy", i), int'(bus.busy), 1);
                chk($sformatf("vec%0d.en_load", i), int'(bus.pwm_enable), 0);
                repeat (int'(PER) * vecs[i].exp_per - 1) tick();
                chk($sformatf("vec%0d.en_last", i), int'(bus.pwm_enable), 1);
                chk($sformatf("vec%0d.done_early", i), int'(bus.done), 0);
                tick();
                chk($sformatf("vec%0d.done", i), int'(bus.done), 1);
                chk($sformatf("vec%0d.en_off", i), int'(bus.pwm_enable), 0);
                chk($sformatf("vec%0d.busy_off", i), int'(bus.busy), 0);
            end
            go_idle();
        end

        // One-shot: (1,1),(3,2).
        wr(0, 1, 1);
        wr(1, 3, 2);
        bus.seq_len = LW'(2); bus.loop = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("os.upd0", int'(bus.pwm_update), 1);
        chk("os.width0", int'(bus.pwm_pulse_width), 1);
        tick();
        chk("os.upd_low", int'(bus.pwm_update), 0);
        chk("os.en1", int'(bus.pwm_enable), 1);
        repeat (7) tick();
        chk("os.upd8", int'(bus.pwm_update), 1);
        chk("os.width8", int'(bus.pwm_pulse_width), 3);
        chk("os.en8", int'(bus.pwm_enable), 1);
        repeat (15) tick();
        chk("os.done23", int'(bus.done), 0);
        chk("os.en23", int'(bus.pwm_enable), 1);
        tick();
        chk("os.done24", int'(bus.done), 1);
        chk("os.en24", int'(bus.pwm_enable), 0);
        go_idle();
        run_check("os", 2, 1'b0, 30, 1000);

        // Loop with width clamp and zero width.
        wr(0, 5, 0);
        wr(1, 0, 1);
        run_check("loop", 2, 1'b1, 30, 1000);

        // stop together with start at a period boundary.
        bus.seq_len = LW'(2); bus.loop = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        bus.stop = 1'b1; bus.start = 1'b1;
        tick();
        bus.stop = 1'b0; bus.start = 1'b0;
        chk("stop.busy", int'(bus.busy), 0);
        chk("stop.en", int'(bus.pwm_enable), 0);
        chk("stop.upd", int'(bus.pwm_update), 0);
        chk("stop.done", int'(bus.done), 0);
        tick();
        chk("stop.busy2", int'(bus.busy), 0);
        chk("stop.upd2", int'(bus.pwm_update), 0);

        // Live write of the playing entry.
        wr(0, 1, 1);
        wr(1, 3, 1);
        bus.seq_len = LW'(2); bus.loop = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        wr(0, 2, 1);
        chk("live.width_now", int'(bus.pwm_pulse_width), 1);
        chk("live.idx_now", int'(bus.cur_index), 0);
        repeat (5) tick();
        chk("live.upd8", int'(bus.pwm_update), 1);
        chk("live.width8", int'(bus.pwm_pulse_width), 3);
        repeat (8) tick();
        chk("live.upd16", int'(bus.pwm_update), 1);
        chk("live.width16", int'(bus.pwm_pulse_width), 2);
        chk("live.idx16", int'(bus.cur_index), 0);
        go_idle();

        // Length clamp.
        for (int i = 0; i < int'(DEPTH); i++) wr(i, i + 1, 1);
        run_check("lenclamp", 7, 1'b0, 40, 1000);

        // Randomized runs against the schedule model.
        for (int r = 0; r < 10; r++) begin
            int len, sa;
            bit lp;
            for (int i = 0; i < int'(DEPTH); i++)
                wr(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            len = int'($urandom_range(0, 7));
            lp  = 1'($urandom_range(0, 1));
            sa  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 50)) : 1000;
            run_check($sformatf("rand%0d", r), len, lp, 60, sa);
        end

        // Asynchronous reset mid-RUN.
        wr(0, 3, 2);
        wr(1, 2, 1);
        bus.seq_len = LW'(2); bus.loop = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.busy", int'(bus.busy), 0);
        chk("arst.en", int'(bus.pwm_enable), 0);
        chk("arst.upd", int'(bus.pwm_update), 0);
        chk("arst.done", int'(bus.done), 0);
        chk("arst.width", int'(bus.pwm_pulse_width), 0);
        chk("arst.idx", int'(bus.cur_index), 0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_w[i] = 0;
            m_h[i] = 0;
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        bus.seq_len = '0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("arst.len0_busy@%0d", c), int'(bus.busy), 0);
            chk($sformatf("arst.len0_upd@%0d", c), int'(bus.pwm_update), 0);
            tick();
        end
        run_check("post_rst", 1, 1'b0, 12, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
